pso_fit_issuer: RTL
===================

// Module: pso_fit_issuer
// PURPOSE
//  Producer side of the particle-fitness stream consumed by the global-best tracker in the PSO MPPT loop.
//  Each sweep steps through NP particle duty values: apply duty, wait for converter settling, sample V/I.
//  It then forms fitness P=V*I and issues {p_fit, addr, ena} with phase tags first/mid/last, then pulses done.
//  Sits between the particle-position store (duty table) and the gbest tracker; also drives the PWM duty.
// PARAMETERS
//  NP      3    particles per sweep (2..15)
//  W       16   width of duty, V, I and fitness
//  SETTLE  16   settle cycles after duty change before sampling (>=1)
//  SHIFT   16   right shift applied to the 2W-bit V*I product
// PORTS
//  clk_P     in   1       system clock
//  reset     in   1       synchronous, active-low reset
//  start     in   1       begin a sweep (sampled only in IDLE)
//  duty_tab  in   NP*W    particle duties; particle k at [k*W +: W]
//  duty_out  out  W       duty to PWM generator
//  adc_req   out  1       conversion request, held until adc_ack
//  adc_ack   in   1       conversion done; v_in/i_in valid this cycle
//  v_in      in   W       PV voltage sample
//  i_in      in   W       PV current sample
//  p_fit     out  W       fitness of current particle
//  addr      out  2       phase tag: 0 idle, 1 first, 2 mid, 3 last
//  ena       out  1       consumer strobe for p_fit/addr
//  busy      out  1       high from start accept until done
//  done      out  1       one-cycle pulse after last particle issued
// BEHAVIOUR
//  Reset (reset==0 at clk_P edge): all outputs 0, idx=0, FSM->IDLE; mid-sweep reset aborts, no done.
//  FSM: IDLE -> APPLY -> SAMPLE -> CALC -> ISSUE -> STROBE -> (APPLY | FIN) -> IDLE.
//   IDLE: start=1 -> idx=0, busy=1, APPLY. start ignored while busy.
//   APPLY: duty_out<=duty_tab[idx]; counter loads SETTLE-1, counts to 0, then SAMPLE.
//   SAMPLE: adc_req=1; on adc_ack capture v_in,i_in, drop adc_req same edge, -> CALC. No timeout.
//   CALC: prod=v*i (2W bits, unsigned); q=prod>>SHIFT; p_fit<=(q>2^W-1)?2^W-1:q (saturate).
//   ISSUE: addr<= (idx==0)?1 : (idx==NP-1)?3 : 2; p_fit/addr now stable, ena=0.
//   STROBE: ena=1 for exactly one cycle; p_fit/addr unchanged. ena lags data by one cycle to
//    match the consumer's input register stage.
//   After STROBE: idx==NP-1 -> FIN else idx+1 -> APPLY.
//   FIN: done=1 one cycle, busy=0, addr<=0; p_fit and duty_out hold last values -> IDLE.
//  NP==2: phases 1 then 3 (no mid). p_fit/addr change only in ISSUE/FIN; never while ena=1.
//  Latency per particle: SETTLE + ADC wait + 4 cycles; adc_ack same cycle as adc_req accepted.
//  adc_ack outside SAMPLE ignored. Duty latched per particle (duty_tab may change between particles).
// STRUCTURE
//  Shared package pso_pkg: phase codes PH_IDLE/FIRST/MID/LAST, FSM state encodings, W default.
//  One sub-module: pso_fit_mul (registered V*I, shift, saturate; CALC = its single cycle).
//  Rest (FSM, idx, settle counter, output regs) in this module.
// TESTING
//  1 NP=3,SETTLE=4, duties 100/200/300, ack 2 cycles after req, V=I=0x0100 -> p_fit=1, addr 1,2,3, 3 ena, done.
//  2 V=I=0xFFFF, SHIFT=0 -> p_fit saturates 0xFFFF; V=0 -> p_fit=0.
//  3 check ena asserted exactly 1 cycle after addr/p_fit update, one cycle wide, data held during ena.
//  4 NP=2 -> addr sequence 1,3; duty_out steps through duty_tab, settles SETTLE cycles before adc_req.
//  5 reset low while in SAMPLE -> all outputs 0 next cycle, no done; new start runs full sweep.
//  6 start pulsed while busy and spurious adc_ack in APPLY -> ignored, sweep output identical to test 1.

Source files
------------

// File: rtl/pso_pkg.sv
// Shared types for the PSO fitness producer: phase tags, FSM states and the default data width.
package pso_pkg;

  localparam int W_DEF = 16;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    PH_IDLE  = 2'd0,
    PH_FIRST = 2'd1,
    PH_MID   = 2'd2,
    PH_LAST  = 2'd3
  } phase_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_APPLY,
    ST_SAMPLE,
    ST_CALC,
    ST_ISSUE,
    ST_STROBE,
    ST_FIN
  } state_t;

  // With only two particles the second one is tagged last, so no mid phase appears.
  function automatic phase_t phase_of(input logic [IDX_W-1:0] idx,
                                      input logic [IDX_W-1:0] last_idx);
    if (idx == '0) return PH_FIRST;
    else if (idx == last_idx) return PH_LAST;
    else return PH_MID;
  endfunction

endpackage

// File: rtl/pso_fit_mul.sv
// Registered fitness unit: P = (V*I) >> SHIFT, saturated to W bits, loaded when en is high.
module pso_fit_mul
  import pso_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int SHIFT = 16
) (
  input  logic         clk_P,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] v,
  input  logic [W-1:0] i,
  output logic [W-1:0] p
);

  logic [2*W-1:0] prod;
  logic [2*W-1:0] q;
  logic [W-1:0]   p_next;

  always_comb begin
    prod   = {{W{1'b0}}, v} * {{W{1'b0}}, i};
    q      = prod >> SHIFT;
    p_next = (|q[2*W-1:W]) ? {W{1'b1}} : q[W-1:0];
  end

  always_ff @(posedge clk_P) begin
    if (!reset) begin
      p <= '0;
    end else if (en) begin
      p <= p_next;
    end
  end

endmodule

// File: rtl/pso_fit_issuer.sv
// Sweeps NP particle duties: apply, settle, sample V/I, then issue saturated fitness with
// first/mid/last tags to the gbest tracker; ena trails the data by one cycle.
module pso_fit_issuer
  import pso_pkg::*;
#(
  parameter int NP     = 3,
  parameter int W      = W_DEF,
  parameter int SETTLE = 16,
  parameter int SHIFT  = 16
) (
  input  logic            clk_P,
  input  logic            reset,
  input  logic            start,
  input  logic [NP*W-1:0] duty_tab,
  output logic [W-1:0]    duty_out,
  output logic            adc_req,
  input  logic            adc_ack,
  input  logic [W-1:0]    v_in,
  input  logic [W-1:0]    i_in,
  output logic [W-1:0]    p_fit,
  output logic [1:0]      addr,
  output logic            ena,
  output logic            busy,
  output logic            done
);

  localparam int               CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NP - 1);
  localparam logic [CW-1:0]    SETTLE_LOAD = CW'(SETTLE - 1);

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;
  logic [CW-1:0]    cnt;
  logic [W-1:0]     v_q;
  logic [W-1:0]     i_q;

  assign next_idx = idx + 1'b1;

  // The multiplier register is the CALC stage; its output is p_fit directly.
  pso_fit_mul #(
    .W     (W),
    .SHIFT (SHIFT)
  ) u_mul (
    .clk_P (clk_P),
    .reset (reset),
    .en    (state == ST_CALC),
    .v     (v_q),
    .i     (i_q),
    .p     (p_fit)
  );

  always_ff @(posedge clk_P) begin
    if (!reset) begin
      state    <= ST_IDLE;
      idx      <= '0;
      cnt      <= '0;
      duty_out <= '0;
      adc_req  <= 1'b0;
      v_q      <= '0;
      i_q      <= '0;
      addr     <= PH_IDLE;
      ena      <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      ena  <= 1'b0;
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx      <= '0;
            busy     <= 1'b1;
            duty_out <= duty_tab[W-1:0];
            cnt      <= SETTLE_LOAD;
            state    <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          if (cnt == '0) begin
            adc_req <= 1'b1;
            state   <= ST_SAMPLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_SAMPLE: begin
          if (adc_ack) begin
            v_q     <= v_in;
            i_q     <= i_in;
            adc_req <= 1'b0;
            state   <= ST_CALC;
          end
        end
        // Tag lands together with the new fitness so both are stable during ISSUE.
        ST_CALC: begin
          addr  <= phase_of(idx, LAST_IDX);
          state <= ST_ISSUE;
        end
        ST_ISSUE: begin
          ena   <= 1'b1;
          state <= ST_STROBE;
        end
        ST_STROBE: begin
          if (idx == LAST_IDX) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            addr  <= PH_IDLE;
            state <= ST_FIN;
          end else begin
            idx      <= next_idx;
            duty_out <= duty_tab[W*int'(next_idx) +: W];
            cnt      <= SETTLE_LOAD;
            state    <= ST_APPLY;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
